nts_api_initiator: RTL and testbench
====================================

NTS_API_INITIATOR -- requirements
Module: nts_api_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: number of WAIT cycles allowed before a transaction is abandoned.
REQ-002 SHALL have port i_clk  input  1  the single clock.
REQ-003 SHALL have port i_areset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports i_req_valid in 1, o_req_ready out 1, i_req_we in 1, i_req_address in 12, i_req_write_data in 32: the request port, with valid/ready handshake.
REQ-005 SHALL have ports o_rsp_valid out 1, i_rsp_ready in 1, o_rsp_data out 32, o_rsp_error out 1: the response port, with valid/ready handshake.
REQ-006 SHALL have ports o_api_cs out 1, o_api_we out 1, o_api_address out 12, o_api_write_data out 32: these drive the external API of the NTS engine.
REQ-007 SHALL have ports i_api_read_data in 32, i_api_read_data_valid in 1, i_api_busy in 1: these are returned by the external API of the NTS engine.

Function
REQ-008 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-009 SHALL drive o_req_ready=1 only when state is IDLE and i_api_busy=0.
REQ-010 SHALL accept a request on the clock edge where i_req_valid and o_req_ready are both high; it SHALL register we, address and write data, then go IDLE->ISSUE.
REQ-011 SHALL assert o_api_cs for exactly one cycle, in ISSUE, with the registered we/address/data presented in that cycle; it SHALL then go ISSUE->WAIT.
REQ-012 SHALL hold o_api_we/address/write_data stable from ISSUE until return to IDLE; these outputs are don't-care after that.
REQ-013 SHALL, in WAIT, capture i_api_read_data when i_api_read_data_valid=1 and go WAIT->RESP, with o_rsp_error=0.
REQ-014 SHALL present o_rsp_data as the captured value for reads and as 0 for writes; writes also wait for i_api_read_data_valid.
REQ-015 SHALL assert o_rsp_valid in RESP and hold o_rsp_valid/data/error stable until i_rsp_ready=1; it SHALL then go RESP->IDLE.
REQ-016 SHALL achieve, against the 4-stage API pipeline, o_rsp_valid 6 cycles after request acceptance: accept T, cs T+1, valid T+5, rsp T+6.
REQ-017 SHALL ignore i_api_read_data_valid in IDLE, ISSUE and RESP; stray or late pulses SHALL NOT alter state or response.
REQ-018 SHALL have no more than one transaction outstanding; cs SHALL never be asserted twice without an intervening valid or timeout.
REQ-019 SHALL reset the timeout counter to 0 on entry to WAIT and increment it each WAIT cycle; it SHALL be wide enough for TIMEOUT_CYCLES with no wrap.
REQ-020 SHALL, when the counter reaches TIMEOUT_CYCLES in WAIT without valid, go to RESP with o_rsp_data=0 and o_rsp_error=1.
REQ-021 SHALL give valid priority on the terminal-count cycle: data captured, error=0.
REQ-022 SHALL accept a new request in the same cycle i_rsp_ready completes RESP only on the following cycle; IDLE is visited for at least 1 cycle.

Reset
REQ-023 SHALL, when i_areset_n=0, immediately force state=IDLE and the counter to 0, and force all outputs to 0: o_req_ready, o_rsp_*, o_api_*.
REQ-024 SHALL, on reset mid-transaction, discard the transaction with no response emitted; after release, o_req_ready follows REQ-009 from the first clock.

Configuration
REQ-025 SHALL, with macro NTS_API_INITIATOR_TIMEOUT_EN defined, include the timeout counter and REQ-019..021.
REQ-026 SHALL, without NTS_API_INITIATOR_TIMEOUT_EN, omit the counter, never leave WAIT except on valid, and tie o_rsp_error to 0.

Structure
REQ-027 SHALL take the FSM state encoding, API_ADDR_WIDTH=12 and API_DATA_WIDTH=32 from the shared package nts_api_pkg.
REQ-028 SHALL be a single module with no sub-module; the counter is inline.

Verification
REQ-029 SHALL cover: read to 12'h011 with model returning 32'hCAFE_0001 at cs+4 -> rsp_valid at accept+6, data CAFE_0001, error 0.
REQ-030 SHALL cover: write 32'h1234_5678 to 12'h205 -> single cs pulse with we=1 and addr 205; rsp data 0, error 0.
REQ-031 SHALL cover: i_api_busy=1 for 10 cycles with req_valid held -> o_req_ready=0 throughout, cs issued the cycle after busy drops.
REQ-032 SHALL cover: with TIMEOUT_EN and TIMEOUT_CYCLES=16, no valid -> rsp at WAIT+16 with error=1 and data 0; a valid at cycle 20 is ignored.
REQ-033 SHALL cover: i_rsp_ready held low 5 cycles -> rsp outputs stable, req_ready=0; a valid pulse during RESP does not change data.
REQ-034 SHALL cover: reset asserted in WAIT -> all outputs 0 asynchronously; a next read after release completes normally.

Source files
------------

// File: rtl/nts_api_pkg.sv
// Shared definitions for the NTS API initiator: bus widths and FSM state encoding.
package nts_api_pkg;

    localparam int API_ADDR_WIDTH = 12;
    localparam int API_DATA_WIDTH = 32;

    // FSM state encoding (kept as plain constants for legacy tool flows)
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Response payload for a completed access: writes return zero, reads return the API data
    function automatic logic [API_DATA_WIDTH-1:0] rsp_payload(
        input logic                      we,
        input logic [API_DATA_WIDTH-1:0] rd
    );
        return we ? {API_DATA_WIDTH{1'b0}} : rd;
    endfunction

endpackage

// File: rtl/nts_api_initiator.sv
// NTS API initiator: turns valid/ready requests into single-cycle chip-select
// accesses on the NTS engine API and returns one response per request.
// Optional feature: define NTS_API_INITIATOR_TIMEOUT_EN to abandon accesses
// that see no read-data-valid within TIMEOUT_CYCLES WAIT cycles (error response).
module nts_api_initiator
    import nts_api_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      i_clk,
    input  logic                      i_areset_n,
    // request port
    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    input  logic                      i_req_we,
    input  logic [API_ADDR_WIDTH-1:0] i_req_address,
    input  logic [API_DATA_WIDTH-1:0] i_req_write_data,
    // response port
    output logic                      o_rsp_valid,
    input  logic                      i_rsp_ready,
    output logic [API_DATA_WIDTH-1:0] o_rsp_data,
    output logic                      o_rsp_error,
    // NTS engine API
    output logic                      o_api_cs,
    output logic                      o_api_we,
    output logic [API_ADDR_WIDTH-1:0] o_api_address,
    output logic [API_DATA_WIDTH-1:0] o_api_write_data,
    input  logic [API_DATA_WIDTH-1:0] i_api_read_data,
    input  logic                      i_api_read_data_valid,
    input  logic                      i_api_busy
);

`ifdef NTS_API_INITIATOR_TIMEOUT_EN
    // Counter must hold TIMEOUT_CYCLES without wrapping
    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0]             r_cnt;
`endif

    logic [1:0]                r_state;
    logic                      r_we;
    logic [API_ADDR_WIDTH-1:0] r_address;
    logic [API_DATA_WIDTH-1:0] r_write_data;
    logic [API_DATA_WIDTH-1:0] r_rsp_data;
    logic                      r_rsp_error;
    logic                      w_req_ready;
    logic                      w_accept;

    // Ready is gated by reset so it reads 0 while reset is held, even though the state is IDLE
    assign w_req_ready = (r_state == ST_IDLE) & ~i_api_busy & i_areset_n;
    assign w_accept    = i_req_valid & w_req_ready;

    assign o_req_ready      = w_req_ready;
    assign o_api_cs         = (r_state == ST_ISSUE);
    assign o_api_we         = r_we;
    assign o_api_address    = r_address;
    assign o_api_write_data = r_write_data;
    assign o_rsp_valid      = (r_state == ST_RESP);
    assign o_rsp_data       = r_rsp_data;
    assign o_rsp_error      = r_rsp_error;

    // Transaction FSM: capture request, issue one cs pulse, wait for data (or timeout), hold response
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_state      <= ST_IDLE;
            r_we         <= 1'b0;
            r_address    <= {API_ADDR_WIDTH{1'b0}};
            r_write_data <= {API_DATA_WIDTH{1'b0}};
            r_rsp_data   <= {API_DATA_WIDTH{1'b0}};
            r_rsp_error  <= 1'b0;
`ifdef NTS_API_INITIATOR_TIMEOUT_EN
            r_cnt        <= {CNT_W{1'b0}};
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_we         <= i_req_we;
                        r_address    <= i_req_address;
                        r_write_data <= i_req_write_data;
                        r_state      <= ST_ISSUE;
                    end else begin
                        r_state      <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
`ifdef NTS_API_INITIATOR_TIMEOUT_EN
                    r_cnt   <= {CNT_W{1'b0}};
`endif
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // valid wins over the terminal count when both land in the same cycle
                    if (i_api_read_data_valid) begin
                        r_rsp_data  <= rsp_payload(r_we, i_api_read_data);
                        r_rsp_error <= 1'b0;
                        r_state     <= ST_RESP;
`ifdef NTS_API_INITIATOR_TIMEOUT_EN
                    end else if (r_cnt == CNT_LAST) begin
                        r_cnt       <= r_cnt + CNT_W'(1);
                        r_rsp_data  <= {API_DATA_WIDTH{1'b0}};
                        r_rsp_error <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_cnt       <= r_cnt + CNT_W'(1);
                        r_state     <= ST_WAIT;
`else
                    end else begin
                        r_state     <= ST_WAIT;
`endif
                    end
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_RESP;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nts_api_initiator.sv
// Randomised self-checking bench for nts_api_initiator with an API responder
// model and a transaction-level reference model of response timing and content.
module tb_nts_api_initiator;

    localparam int TO = 16;
`ifdef NTS_API_INITIATOR_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_we = 1'b0;
    logic [11:0] i_req_address = 12'h000;
    logic [31:0] i_req_write_data = 32'h0;
    logic        o_rsp_valid;
    logic        i_rsp_ready = 1'b0;
    logic [31:0] o_rsp_data;
    logic        o_rsp_error;
    logic        o_api_cs;
    logic        o_api_we;
    logic [11:0] o_api_address;
    logic [31:0] o_api_write_data;
    logic [31:0] i_api_read_data = 32'h0;
    logic        i_api_read_data_valid = 1'b0;
    logic        i_api_busy = 1'b0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    nts_api_initiator #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk                 (clk),
        .i_areset_n            (rst_n),
        .i_req_valid           (i_req_valid),
        .o_req_ready           (o_req_ready),
        .i_req_we              (i_req_we),
        .i_req_address         (i_req_address),
        .i_req_write_data      (i_req_write_data),
        .o_rsp_valid           (o_rsp_valid),
        .i_rsp_ready           (i_rsp_ready),
        .o_rsp_data            (o_rsp_data),
        .o_rsp_error           (o_rsp_error),
        .o_api_cs              (o_api_cs),
        .o_api_we              (o_api_we),
        .o_api_address         (o_api_address),
        .o_api_write_data      (o_api_write_data),
        .i_api_read_data       (i_api_read_data),
        .i_api_read_data_valid (i_api_read_data_valid),
        .i_api_busy            (i_api_busy)
    );

    // free-running clock and cycle index
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // One full transaction. lat = cycles from cs to the API valid pulse.
    task automatic run_txn(input logic we, input logic [11:0] addr, input logic [31:0] wd,
                           input logic [31:0] rd, input int lat, input int hold, input int busy);
        int acc, bstart, n, exp_cyc;
        logic exp_err;
        logic [31:0] exp_data;
        bit got;

        // stray valid while idle must be ignored
        i_api_read_data_valid = 1'b1;
        i_api_read_data = $urandom;
        tick();
        i_api_read_data_valid = 1'b0;
        chk("idle_stray", {62'd0, o_rsp_valid, o_api_cs}, 64'd0);

        i_req_valid = 1'b1;
        i_req_we = we;
        i_req_address = addr;
        i_req_write_data = wd;
        bstart = cyc;
        for (int k = 0; k < busy; k++) begin
            i_api_busy = 1'b1;
            #1 chk("busy_rdy", {63'd0, o_req_ready}, 64'd0);
            tick();
        end
        i_api_busy = 1'b0;
        #1;
        n = 0;
        while (!o_req_ready && n < 20) begin
            tick();
            #1;
            n++;
        end
        chk("req_rdy", {63'd0, o_req_ready}, 64'd1);
        acc = cyc;
        if (busy > 0) chk("busy_acc", 64'(acc), 64'(bstart + busy));

        // reference model: response timing and content from the rules
        if (TO_EN && lat > TO) begin
            exp_cyc = acc + 2 + TO;
            exp_err = 1'b1;
            exp_data = 32'h0;
        end else begin
            exp_cyc = acc + 2 + lat;
            exp_err = 1'b0;
            exp_data = we ? 32'h0 : rd;
        end

        tick();
        i_req_valid = 1'b0;
        i_req_we = 1'($urandom);
        i_req_address = 12'($urandom);
        i_req_write_data = $urandom;
        chk("issue", {19'd0, o_api_cs, o_api_we, o_api_address, o_api_write_data},
                     {19'd0, 1'b1, we, addr, wd});

        got = 1'b0;
        n = 0;
        while (!got && n < 60) begin
            i_api_read_data_valid = (cyc == acc + 1 + lat);
            i_api_read_data = i_api_read_data_valid ? rd : $urandom;
            tick();
            n++;
            if (o_rsp_valid) got = 1'b1;
            else chk("wait_hold", {19'd0, o_api_cs, o_api_we, o_api_address, o_api_write_data},
                                  {19'd0, 1'b0, we, addr, wd});
        end
        i_api_read_data_valid = 1'b0;
        chk("rsp_seen", {63'd0, got}, 64'd1);
        if (!got) return;
        chk("rsp_cyc", 64'(cyc), 64'(exp_cyc));
        chk("rsp_data", {32'd0, o_rsp_data}, {32'd0, exp_data});
        chk("rsp_err", {63'd0, o_rsp_error}, {63'd0, exp_err});
        chk("resp_api", {20'd0, o_api_we, o_api_address, o_api_write_data}, {20'd0, we, addr, wd});

        for (int h = 0; h < hold; h++) begin
            i_rsp_ready = 1'b0;
            i_api_read_data_valid = (cyc == acc + 1 + lat) || ($urandom_range(0, 1) == 1);
            i_api_read_data = $urandom;
            tick();
            chk("hold", {29'd0, o_rsp_valid, o_rsp_error, o_req_ready, o_rsp_data},
                        {29'd0, 1'b1, exp_err, 1'b0, exp_data});
        end
        i_api_read_data_valid = 1'b0;
        i_rsp_ready = 1'b1;
        tick();
        i_rsp_ready = 1'b0;
        #1 chk("back_idle", {61'd0, o_rsp_valid, o_api_cs, o_req_ready}, {61'd0, 1'b0, 1'b0, 1'b1});
    endtask

    initial begin
        int lat, lo, hi;
        // reset state
        #1 chk("rst_a", {12'd0, o_req_ready, o_rsp_valid, o_rsp_error, o_api_cs, o_api_we, o_api_address, o_rsp_data[15:0]}, 64'd0);
        chk("rst_b", {o_rsp_data, o_api_write_data}, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1 chk("rst_rel_rdy", {63'd0, o_req_ready}, 64'd1);

        // directed: read, write, busy, held response
        run_txn(1'b0, 12'h011, 32'h0, 32'hCAFE_0001, 4, 0, 0);
        run_txn(1'b1, 12'h205, 32'h1234_5678, 32'hDEAD_BEEF, 4, 0, 0);
        run_txn(1'b0, 12'h3A0, 32'h0, 32'h5555_AAAA, 4, 0, 10);
        run_txn(1'b0, 12'h0FF, 32'h0, 32'h0BAD_F00D, 3, 5, 0);
        run_txn(1'b0, 12'h001, 32'h0, 32'h1111_2222, 1, 1, 0);
`ifdef NTS_API_INITIATOR_TIMEOUT_EN
        run_txn(1'b0, 12'h123, 32'h0, 32'h7777_0000, 20, 6, 0);
        run_txn(1'b0, 12'h124, 32'h0, 32'h7777_0016, TO, 1, 0);
        run_txn(1'b1, 12'h125, 32'hABCD_0000, 32'h7777_0017, TO + 1, 2, 0);
`endif

        // reset while waiting on a write: everything drops to 0 at once
        i_req_valid = 1'b1;
        i_req_we = 1'b1;
        i_req_address = 12'hABC;
        i_req_write_data = 32'hFEED_FACE;
        tick();
        i_req_valid = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1 chk("rst_wait_a", {12'd0, o_req_ready, o_rsp_valid, o_rsp_error, o_api_cs, o_api_we, o_api_address, o_rsp_data[15:0]}, 64'd0);
        chk("rst_wait_b", {o_rsp_data, o_api_write_data}, 64'd0);
        tick();
        rst_n = 1'b1;
        #1 chk("rst_wait_rdy", {62'd0, o_req_ready, o_rsp_valid}, {62'd0, 1'b1, 1'b0});
        run_txn(1'b0, 12'h011, 32'h0, 32'hCAFE_0002, 4, 0, 0);

        // randomised transactions
        lo = 1;
        hi = TO_EN ? TO + 6 : 12;
        for (int t = 0; t < 40; t++) begin
            lat = $urandom_range(hi, lo);
            run_txn(1'($urandom), 12'($urandom), $urandom, $urandom, lat,
                    $urandom_range(4, 0), $urandom_range(3, 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
